// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO ingress arbiter.
// Holds the arbiter state encoding and the modulo-increment used for pointer wrap.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HOLD  = 2'd1,
    ARB_STALL = 2'd2
  } arb_state_t;

  // Increment with wrap at n; n need not be a power of two.
  function automatic int unsigned idx_wrap(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin pick: first set bit of req at or after start, wrapping modulo N.
// Implemented as rotate, lowest-bit priority encode, then un-rotate.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  pos;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pos = IW'(k);
    end
    sum = {1'b0, start} + {1'b0, pos};
    if (sum >= N_W) sum = sum - N_W;
    found = |req;
    idx   = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO ingress port between N_REQ valid/ready producers.
// Define FIFO_ARB_STATS_EN to add the saturating per-requester grant_cnt counters.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0] out_src,
  input  logic                     out_ready
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]   grant_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW:0] BURST_W = (BW+1)'(MAX_BURST);

  // Handshake: a beat moves when out_valid && out_ready; the granted requester
  // sees req_ready in that same cycle, and must hold valid/data while stalled.
  arb_state_t     state, state_n;
  logic [IW-1:0]  rr_ptr, rr_n, owner, owner_n;
  logic [BW-1:0]  beat_cnt, beat_n;
  logic [WIDTH-1:0] last_data;
  logic [IW-1:0]  last_src;

  logic           rr_found, rel_found;
  logic [IW-1:0]  rr_idx, rel_idx, owner_inc;
  logic           sel_valid;
  logic [IW-1:0]  grant;
  logic [BW-1:0]  cnt_base;
  logic [IW-1:0]  ptr_base;

  assign owner_inc = IW'(idx_wrap(32'(owner), N_REQ));

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick_rr (
    .req   (req_valid),
    .start (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick_rel (
    .req   (req_valid),
    .start (owner_inc),
    .found (rel_found),
    .idx   (rel_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      last_data <= '0;
      last_src  <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      owner    <= owner_n;
      beat_cnt <= beat_n;
      if (out_valid) begin
        last_data <= out_data;
        last_src  <= out_src;
      end
    end
  end

  // Grant selection; a dropped owner releases to owner+1 in the same cycle.
  always_comb begin
    sel_valid = rr_found;
    grant     = rr_idx;
    cnt_base  = '0;
    ptr_base  = rr_ptr;
    case (state)
      ARB_HOLD: begin
        if (req_valid[owner]) begin
          sel_valid = 1'b1;
          grant     = owner;
          cnt_base  = beat_cnt;
        end else begin
          sel_valid = rel_found;
          grant     = rel_idx;
          ptr_base  = owner_inc;
        end
      end
      ARB_STALL: begin
        if (req_valid[owner]) begin
          sel_valid = 1'b1;
          grant     = owner;
          cnt_base  = beat_cnt;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    beat_n  = beat_cnt;
    if (sel_valid) begin
      if (out_ready) begin
        if (({1'b0, cnt_base} + 1'b1) < BURST_W) begin
          state_n = ARB_HOLD;
          owner_n = grant;
          beat_n  = cnt_base + 1'b1;
          rr_n    = ptr_base;
        end else begin
          state_n = ARB_IDLE;
          owner_n = grant;
          beat_n  = '0;
          rr_n    = IW'(idx_wrap(32'(grant), N_REQ));
        end
      end else begin
        state_n = ARB_STALL;
        owner_n = grant;
        beat_n  = cnt_base;
        rr_n    = ptr_base;
      end
    end else begin
      state_n = ARB_IDLE;
      beat_n  = '0;
      rr_n    = ptr_base;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of req_valid.
  always_comb begin
    out_valid = rst && sel_valid;
    req_ready = '0;
    if (out_valid && out_ready) req_ready[grant] = 1'b1;
    out_data  = out_valid ? req_data[grant*WIDTH +: WIDTH] : last_data;
    out_src   = out_valid ? grant : last_src;
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (out_valid && out_ready && grant == IW'(g) && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed scoreboard bench for fifo_rr_arbiter: per-beat and burst instances.
// Grant-counter checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;

  logic [3:0] v1, rr1, v4, rr4;
  logic       o1, o4, ov1, ov4;
  logic [7:0] od1, od4;
  logic [1:0] os1, os4;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] gc1, gc4;
`endif

  logic [9:0] exp1_q[$];
  logic [9:0] exp4_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(1), .CNT_W(4)) u_b1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_data(req_data), .req_ready(rr1),
    .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(o1)
`ifdef FIFO_ARB_STATS_EN
    , .grant_cnt(gc1)
`endif
  );

  fifo_rr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4), .CNT_W(4)) u_b4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_data(req_data), .req_ready(rr4),
    .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(o4)
`ifdef FIFO_ARB_STATS_EN
    , .grant_cnt(gc4)
`endif
  );

  // Expected beat = {source id, data}; requester i always presents 0xA0+i.
  function automatic logic [9:0] beat(input int s);
    return {2'(s), 8'(160 + s)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    v1 = '0; v4 = '0; o1 = 1'b0; o4 = 1'b0;
    #1;
    chk("rst_b1_out_valid", 32'(ov1), 0);
    chk("rst_b1_out_src", 32'(os1), 0);
    chk("rst_b4_out_valid", 32'(ov4), 0);
    chk("rst_b4_req_ready", 32'(rr4), 0);
    chk("rst_b4_out_data", 32'(od4), 0);
    chk("rst_b4_out_src", 32'(os4), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_b4_grant_cnt", 32'(gc4), 0);
`endif
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  always @(negedge clk) begin
    if (rst && ov1 && o1) begin
      n_cmp++;
      if (exp1_q.size() == 0) begin
        n_err++;
        $display("FAIL b1_unexpected_beat: got src=%0d data=0x%0h expected none", os1, od1);
      end else begin
        logic [9:0] e;
        e = exp1_q.pop_front();
        if ({os1, od1} !== e) begin
          n_err++;
          $display("FAIL b1_beat: got src=%0d data=0x%0h expected src=%0d data=0x%0h",
                   os1, od1, e[9:8], e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ov4 && o4) begin
      n_cmp++;
      if (exp4_q.size() == 0) begin
        n_err++;
        $display("FAIL b4_unexpected_beat: got src=%0d data=0x%0h expected none", os4, od4);
      end else begin
        logic [9:0] e;
        e = exp4_q.pop_front();
        if ({os4, od4} !== e) begin
          n_err++;
          $display("FAIL b4_beat: got src=%0d data=0x%0h expected src=%0d data=0x%0h",
                   os4, od4, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    do_reset();

    // Per-beat rotation, all requesters valid.
    v1 = 4'hF; o1 = 1'b1;
    exp1_q.push_back(beat(0)); exp1_q.push_back(beat(1));
    exp1_q.push_back(beat(2)); exp1_q.push_back(beat(3));
    exp1_q.push_back(beat(0));
    repeat (5) step();
    v1 = '0;
    step();

    // Bursts of four alternating between requesters 1 and 2.
    do_reset();
    v4 = 4'b0110; o4 = 1'b1;
    for (int i = 0; i < 4; i++) exp4_q.push_back(beat(1));
    for (int i = 0; i < 4; i++) exp4_q.push_back(beat(2));
    exp4_q.push_back(beat(1));
    repeat (9) step();
    v4 = '0;
    #1;
    chk("idle_out_valid", 32'(ov4), 0);
    chk("idle_hold_src", 32'(os4), 1);
    chk("idle_hold_data", 32'(od4), 32'hA1);
    step();

    // Stall on requester 3; a late requester 0 must not steal the grant.
    do_reset();
    v4 = 4'b1000; o4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_src", 32'(os4), 3);
      chk("stall_valid", 32'(ov4), 1);
      chk("stall_ready", 32'(rr4), 0);
      step();
    end
    v4 = 4'b1001;
    #1;
    chk("stall_late_src", 32'(os4), 3);
    chk("stall_late_ready", 32'(rr4), 0);
    step();
    o4 = 1'b1;
    exp4_q.push_back(beat(3));
    #1;
    chk("stall_exit_ready", 32'(rr4), 32'b1000);
    step();
    v4 = '0;
    step();

    // Owner 2 drops after two beats; requester 0 granted with no bubble.
    do_reset();
    v4 = 4'b0100; o4 = 1'b1;
    exp4_q.push_back(beat(2)); exp4_q.push_back(beat(2));
    repeat (2) step();
    v4 = 4'b0001;
    exp4_q.push_back(beat(0));
    #1;
    chk("release_src", 32'(os4), 0);
    chk("release_valid", 32'(ov4), 1);
    step();
    v4 = '0;
    step();

    // Asynchronous reset in the middle of a burst.
    do_reset();
    v4 = 4'hF; o4 = 1'b1;
    exp4_q.push_back(beat(0)); exp4_q.push_back(beat(0));
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov4), 0);
    chk("midrst_ready", 32'(rr4), 0);
    chk("midrst_src", 32'(os4), 0);
    chk("midrst_data", 32'(od4), 0);
    step();
    rst = 1'b1;
    exp4_q.push_back(beat(0));
    #1;
    chk("postrst_src", 32'(os4), 0);
    step();
    v4 = '0;
    step();

`ifdef FIFO_ARB_STATS_EN
    // Counter saturation at 2^4-1 after twenty beats from requester 1.
    do_reset();
    v4 = 4'b0010; o4 = 1'b1;
    for (int i = 0; i < 20; i++) exp4_q.push_back(beat(1));
    repeat (20) step();
    v4 = '0;
    #1;
    chk("stats_cnt0", 32'(gc4[3:0]), 0);
    chk("stats_cnt1", 32'(gc4[7:4]), 15);
    chk("stats_cnt2", 32'(gc4[11:8]), 0);
    chk("stats_cnt3", 32'(gc4[15:12]), 0);
    step();
`endif

    chk("b1_queue_drained", 32'(exp1_q.size()), 0);
    chk("b4_queue_drained", 32'(exp4_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
